axi_write_queue: RTL and testbench

Parametrised posted-write engine between the data cache and the AXI master port. It accepts single-word and full-line writes into a DEPTH-entry queue and drains them in order as AXI INCR bursts. AW and W are issued concurrently, and each entry retires on its B response. It adds a line-granular hazard check, so the read path stalls only when a read targets a line with a pending write, instead of waiting for the whole queue to empty.

---
 rtl/axi_write_queue_pkg.sv | 18 +
 rtl/axi_write_queue_if.sv | 45 ++++
 rtl/axi_write_queue_line_match.sv | 21 ++
 rtl/axi_write_queue.sv | 171 +++++++++++++++++
 tb/tb_axi_write_queue.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_write_queue_pkg.sv
// rtl/axi_write_queue_pkg.sv - shared encodings and drain-state enum for the posted-write queue
package axi_write_queue_pkg;

    localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
    localparam logic [2:0] WR_TYPE_HALF = 3'b001;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_B
    } drain_state_e;

endpackage

// File: rtl/axi_write_queue_if.sv
// rtl/axi_write_queue_if.sv - AXI write-channel bundle (AW, W, B) between queue and interconnect
interface axi_write_queue_if;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_write_queue_line_match.sv
// rtl/axi_write_queue_line_match.sv - parallel line-tag compare of every pending entry against a read
module axi_write_queue_line_match #(
    parameter int DEPTH = 4,
    parameter int TW    = 28
) (
    input  logic [TW-1:0]    tag [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [TW-1:0]    chk_tag,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag[i] == chk_tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_write_queue.sv
// rtl/axi_write_queue.sv - posted-write queue draining in order as AXI INCR bursts with line hazard check
module axi_write_queue #(
    parameter int         DEPTH      = 4,
    parameter int         LINE_WORDS = 4,
    parameter logic [3:0] AXI_ID     = 4'd1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_req,
    input  logic [2:0]               wr_type,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    input  logic [31:0]              chk_addr,
    output logic                     chk_hit,
    output logic                     empty,
    output logic                     err,
    axi_write_queue_if.master        axi
);
    import axi_write_queue_pkg::*;

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFS = $clog2(LINE_WORDS * 4);
    localparam int TW  = 32 - OFS;

    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH][LINE_WORDS];
    logic [3:0]  strb_q [DEPTH];
    logic [7:0]  len_q  [DEPTH];
    logic [2:0]  size_q [DEPTH];

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    drain_state_e  state;
    logic [BW-1:0] beat;
    logic          awvalid_q, wvalid_q, wlast_q, bready_q, err_q;

    logic enq, retire, b_match, aw_fire, w_fire, act;

    assign wr_rdy  = count < CW'(DEPTH);
    assign empty   = count == '0;
    assign enq     = wr_req && wr_rdy;
    assign b_match = axi.bvalid && (axi.bid == AXI_ID);
    assign retire  = bready_q && b_match;
    assign aw_fire = awvalid_q && axi.awready;
    assign w_fire  = wvalid_q && axi.wready;
    assign act     = state == XFER;

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= wr_addr;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[tail][w] <= wr_data[w*32 +: 32];
            end
            if (wr_type == WR_TYPE_LINE) begin
                strb_q[tail] <= 4'hF;
                len_q[tail]  <= 8'(LINE_WORDS - 1);
                size_q[tail] <= 3'd2;
            end else begin
                strb_q[tail] <= wr_wstrb;
                len_q[tail]  <= 8'd0;
                size_q[tail] <= wr_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)    tail <= tail + PW'(1);
            if (retire) head <= head + PW'(1);
            count <= count + CW'(enq) - CW'(retire);
        end
    end

    // awvalid_q/wvalid_q double as the inverse of the aw_done/w_done flags while in XFER
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            beat      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        beat      <= '0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= len_q[head] == 8'd0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                        end else begin
                            beat    <= beat + BW'(1);
                            wlast_q <= (8'(beat) + 8'd1) == len_q[head];
                        end
                    end
                    if ((!awvalid_q || aw_fire) && (!wvalid_q || (w_fire && wlast_q))) begin
                        state    <= WAIT_B;
                        bready_q <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_match) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                        if (axi.bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign err = err_q;

    // payload is forced to zero outside XFER so reset and idle show a quiet bus
    assign axi.awid    = act ? AXI_ID : '0;
    assign axi.awaddr  = act ? addr_q[head] : '0;
    assign axi.awlen   = act ? len_q[head] : '0;
    assign axi.awsize  = act ? size_q[head] : '0;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = act ? AXI_ID : '0;
    assign axi.wdata   = act ? data_q[head][beat] : '0;
    assign axi.wstrb   = act ? strb_q[head] : '0;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    logic [TW-1:0]    tag [DEPTH];
    logic [DEPTH-1:0] valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag[i]   = addr_q[i][31:OFS];
            valid[i] = {1'b0, PW'(i) - head} < count;
        end
    end

    axi_write_queue_line_match #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_line_match (
        .tag     (tag),
        .valid   (valid),
        .chk_tag (chk_addr[31:OFS]),
        .hit     (chk_hit)
    );

endmodule

// File: tb/tb_axi_write_queue.sv
// tb/tb_axi_write_queue.sv - self-checking bench for axi_write_queue with queue-level reference model
module tb_axi_write_queue;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic [3:0]   strb;
        logic [7:0]   len;
        logic [2:0]   size;
    } ent_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         empty;
    logic         err;

    axi_write_queue_if axi();

    axi_write_queue #(
        .DEPTH      (4),
        .LINE_WORDS (4),
        .AXI_ID     (4'd1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_req   (wr_req),
        .wr_type  (wr_type),
        .wr_addr  (wr_addr),
        .wr_wstrb (wr_wstrb),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .empty    (empty),
        .err      (err),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of accepted writes plus progress of the head burst
    ent_t q[$];
    ent_t m_h, m_new;
    int   m_beat;
    bit   m_aw_seen, m_w_done, m_waitb, m_err, m_hz, mon_en;

    always @(negedge clk) begin
        if (mon_en) begin
            m_hz = 1'b0;
            foreach (q[i]) if (q[i].addr[31:4] == chk_addr[31:4]) m_hz = 1'b1;
            chk("m_wr_rdy", wr_rdy, q.size() < 4);
            chk("m_empty", empty, q.size() == 0);
            chk("m_chk_hit", chk_hit, m_hz);
            chk("m_err", err, m_err);
            chk("m_bready", axi.bready, m_waitb);
            if (q.size() == 0 || m_aw_seen || m_waitb) chk("m_awvalid_off", axi.awvalid, 0);
            if (q.size() == 0 || m_w_done || m_waitb) chk("m_wvalid_off", axi.wvalid, 0);
            if (!axi.wvalid) chk("m_wlast_off", axi.wlast, 0);
            if (q.size() > 0) begin
                m_h = q[0];
                if (axi.awvalid) begin
                    chk("m_awaddr", axi.awaddr, m_h.addr);
                    chk("m_awlen", axi.awlen, m_h.len);
                    chk("m_awsize", axi.awsize, m_h.size);
                    chk("m_awburst", axi.awburst, 2'b01);
                    chk("m_awid", axi.awid, 4'd1);
                end
                if (axi.wvalid) begin
                    chk("m_wdata", axi.wdata, m_h.data[m_beat*32 +: 32]);
                    chk("m_wstrb", axi.wstrb, m_h.strb);
                    chk("m_wlast", axi.wlast, m_beat == int'(m_h.len));
                    chk("m_wid", axi.wid, 4'd1);
                end
            end
            if (!resetn) begin
                q.delete();
                m_beat = 0; m_aw_seen = 0; m_w_done = 0; m_waitb = 0; m_err = 0;
            end else begin
                if (q.size() > 0 && m_waitb && axi.bvalid && axi.bid == 4'd1) begin
                    if (axi.bresp != 2'b00) m_err = 1'b1;
                    void'(q.pop_front());
                    m_beat = 0; m_aw_seen = 0; m_w_done = 0; m_waitb = 0;
                end else if (q.size() > 0) begin
                    if (axi.awvalid && axi.awready) m_aw_seen = 1'b1;
                    if (axi.wvalid && axi.wready) begin
                        if (m_beat == int'(m_h.len)) m_w_done = 1'b1;
                        else m_beat++;
                    end
                    if (m_aw_seen && m_w_done) m_waitb = 1'b1;
                end
                if (wr_req && q.size() < 4) begin
                    m_new.addr = wr_addr;
                    if (wr_type == 3'b100) begin
                        m_new.data = wr_data;
                        m_new.strb = 4'hF;
                        m_new.len  = 8'd3;
                        m_new.size = 3'd2;
                    end else begin
                        m_new.data = {96'd0, wr_data[31:0]};
                        m_new.strb = wr_wstrb;
                        m_new.len  = 8'd0;
                        m_new.size = wr_type;
                    end
                    q.push_back(m_new);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s, input logic [127:0] d);
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic wait_bready();
        int n = 0;
        while (axi.bready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("wait_bready", axi.bready, 1);
    endtask

    task automatic wait_valid(input bit aw);
        int n = 0;
        while ((aw ? axi.awvalid : axi.wvalid) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(aw ? "wait_awvalid" : "wait_wvalid", aw ? axi.awvalid : axi.wvalid, 1);
    endtask

    task automatic give_b(input logic [3:0] id, input logic [1:0] resp);
        axi.bvalid = 1'b1; axi.bid = id; axi.bresp = resp;
        tick();
        axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'd0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            wait_bready();
            give_b(4'd1, 2'b00);
        end
    endtask

    logic [31:0] line_words [4];

    initial begin
        line_words = '{32'h11, 32'h22, 32'h33, 32'h44};
        resetn = 1'b0; wr_req = 1'b0; wr_type = 3'd0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        chk_addr = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'd0;
        mon_en = 1'b0;
        tick(); tick(); tick();
        mon_en = 1'b1;

        chk("rst_wr_rdy", wr_rdy, 1);
        chk("rst_empty", empty, 1);
        chk("rst_chk_hit", chk_hit, 0);
        chk("rst_err", err, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_wlast", axi.wlast, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_awlock", {axi.awlock, axi.awcache, axi.awprot}, 0);
        resetn = 1'b1;
        tick();

        // line write, both channels ready
        axi.awready = 1'b1; axi.wready = 1'b1;
        enq(3'b100, 32'h1000, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("line_not_empty", empty, 0);
        chk("line_aw_latency", axi.awvalid, 0);
        tick();
        chk("line_awvalid", axi.awvalid, 1);
        chk("line_awaddr", axi.awaddr, 32'h1000);
        chk("line_awlen", axi.awlen, 3);
        chk("line_awsize", axi.awsize, 2);
        chk("line_awburst", axi.awburst, 1);
        for (int b = 0; b < 4; b++) begin
            chk("line_wvalid", axi.wvalid, 1);
            chk("line_wdata", axi.wdata, line_words[b]);
            chk("line_wlast", axi.wlast, b == 3);
            chk("line_wstrb", axi.wstrb, 4'hF);
            tick();
        end
        chk("line_bready", axi.bready, 1);
        chk("line_wvalid_done", axi.wvalid, 0);
        give_b(4'd1, 2'b00);
        chk("line_empty_after_b", empty, 1);
        chk("line_bready_after_b", axi.bready, 0);

        // line hazard
        axi.awready = 1'b0; axi.wready = 1'b0;
        enq(3'd2, 32'h2004, 4'hF, 128'hDEADBEEF);
        chk_addr = 32'h200C; #1;
        chk("hz_same_line", chk_hit, 1);
        chk_addr = 32'h2010; #1;
        chk("hz_next_line", chk_hit, 0);
        chk_addr = 32'h200C;
        axi.awready = 1'b1; axi.wready = 1'b1;
        wait_bready();
        give_b(4'd1, 2'b00);
        #1;
        chk("hz_after_retire", chk_hit, 0);

        // fill to DEPTH, refuse the fifth, free one slot
        axi.awready = 1'b0; axi.wready = 1'b0; chk_addr = '0;
        enq(3'd0, 32'h3000, 4'h1, 128'hA0A0A0A0);
        enq(3'd1, 32'h3004, 4'h3, 128'hA1A1A1A1);
        enq(3'd2, 32'h3008, 4'hF, 128'hA2A2A2A2);
        enq(3'd2, 32'h300C, 4'hF, 128'hA3A3A3A3);
        chk("fill_full", wr_rdy, 0);
        wr_req = 1'b1; wr_type = 3'd2; wr_addr = 32'h4000; wr_data = 128'hBAD;
        tick(); tick();
        wr_req = 1'b0;
        chk("fill_still_full", wr_rdy, 0);
        axi.awready = 1'b1; axi.wready = 1'b1;
        wait_bready();
        axi.bvalid = 1'b1; axi.bid = 4'd1; axi.bresp = 2'b00;
        #1;
        chk("fill_rdy_in_retire", wr_rdy, 0);
        tick();
        axi.bvalid = 1'b0;
        chk("fill_rdy_after_retire", wr_rdy, 1);
        drain(3);
        chk("fill_drained", empty, 1);

        // AW held off while W completes
        axi.awready = 1'b0; axi.wready = 1'b1;
        enq(3'b100, 32'h5000, 4'h0, {32'h53, 32'h52, 32'h51, 32'h50});
        wait_valid(1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("skew_awaddr", axi.awaddr, 32'h5000);
            chk("skew_no_bready", axi.bready, 0);
            tick();
        end
        chk("skew_w_done", axi.wvalid, 0);
        chk("skew_aw_pending", axi.awvalid, 1);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        chk("skew_bready", axi.bready, 1);

        // foreign B ignored, then error response
        axi.bvalid = 1'b1; axi.bid = 4'd0; axi.bresp = 2'b00;
        tick(); tick();
        chk("b_foreign_bready", axi.bready, 1);
        chk("b_foreign_pending", empty, 0);
        axi.bid = 4'd1; axi.bresp = 2'b10;
        tick();
        axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'd0;
        chk("b_err_retired", empty, 1);
        chk("b_err_set", err, 1);
        axi.awready = 1'b1; axi.wready = 1'b1;
        enq(3'd2, 32'h7000, 4'hF, 128'h77);
        drain(1);
        chk("b_err_sticky", err, 1);

        // reset during the second W beat
        enq(3'b100, 32'h6000, 4'h0, {32'h64, 32'h63, 32'h62, 32'h61});
        wait_valid(1'b0);
        tick();
        chk("rst_mid_beat2", axi.wdata, 32'h62);
        resetn = 1'b0;
        tick();
        chk("rst_mid_awvalid", axi.awvalid, 0);
        chk("rst_mid_wvalid", axi.wvalid, 0);
        chk("rst_mid_bready", axi.bready, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_wr_rdy", wr_rdy, 1);
        chk("rst_mid_err", err, 0);
        resetn = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
